// File: rtl/mha_head_sequencer.sv
// rtl/mha_head_sequencer.sv - score/load/scale/softmax/gemm sequencer for the multi-head attention datapath (optional watchdog: ATTN_SEQ_WATCHDOG_EN)
module mha_head_sequencer #(
    parameter int                NUM_HEADS  = 4,
    parameter int                WDOG_W     = 16,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF,
    localparam int               HSW        = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic           score_start,
    input  logic           score_done,
    output logic           load_start,
    input  logic           load_done,
    output logic           scale_start,
    input  logic           scale_done,
    output logic           sm_start,
    input  logic [3:0]     sm_done,
    output logic           gemm_start,
    input  logic           gemm_done,
    output logic [HSW-1:0] head_sel,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2:0]     err_stage
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SCORE_W = 4'd1;
    localparam logic [3:0] S_LOAD_W  = 4'd2;
    localparam logic [3:0] S_SCALE_W = 4'd3;
    localparam logic [3:0] S_SM_W    = 4'd4;
    localparam logic [3:0] S_GEMM_W  = 4'd5;
    localparam logic [3:0] S_NEXT    = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERR     = 4'd8;

    localparam logic [HSW-1:0] HEAD_LAST = HSW'(NUM_HEADS - 1);

    logic [3:0] state;
    logic [3:0] state_nx;
    logic       start_d;
    logic [3:0] sm_seen;

`ifdef ATTN_SEQ_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic [2:0]        stage_code;

    // Error code of the stage being waited on; zero outside wait states
    always_comb begin
        stage_code = 3'd0;
        case (state)
            S_SCORE_W: stage_code = 3'd1;
            S_LOAD_W:  stage_code = 3'd2;
            S_SCALE_W: stage_code = 3'd3;
            S_SM_W:    stage_code = 3'd4;
            S_GEMM_W:  stage_code = 3'd5;
            default:   stage_code = 3'd0;
        endcase
    end
`endif

    // Next-state: stage handshakes, then watchdog trap, then abort overrides everything
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start && !start_d) state_nx = S_SCORE_W;
            S_SCORE_W: if (score_done) state_nx = S_LOAD_W;
            S_LOAD_W:  if (load_done) state_nx = S_SCALE_W;
            S_SCALE_W: if (scale_done) state_nx = S_SM_W;
            S_SM_W:    if ((sm_seen | sm_done) == 4'hF) state_nx = S_GEMM_W;
            S_GEMM_W:  if (gemm_done) state_nx = S_NEXT;
            S_NEXT:    state_nx = (head_sel == HEAD_LAST) ? S_DONE : S_LOAD_W;
            S_DONE:    state_nx = S_IDLE;
            S_ERR:     state_nx = S_ERR;
            default:   state_nx = S_IDLE;
        endcase
`ifdef ATTN_SEQ_WATCHDOG_EN
        // A done arriving on the limit cycle has already moved state_nx, so it wins
        if ((stage_code != 3'd0) && (state_nx == state) &&
            (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1'b1)))
            state_nx = S_ERR;
`endif
        if (abort)
            state_nx = S_IDLE;
    end

    // State, registered outputs derived from the upcoming state, head index and softmax row tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            start_d     <= 1'b0;
            score_start <= 1'b0;
            load_start  <= 1'b0;
            scale_start <= 1'b0;
            sm_start    <= 1'b0;
            gemm_start  <= 1'b0;
            head_sel    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sm_seen     <= 4'h0;
        end else begin
            state       <= state_nx;
            start_d     <= start;
            score_start <= (state_nx == S_SCORE_W) && (state != S_SCORE_W);
            load_start  <= (state_nx == S_LOAD_W)  && (state != S_LOAD_W);
            scale_start <= (state_nx == S_SCALE_W);
            sm_start    <= (state_nx == S_SM_W)    && (state != S_SM_W);
            gemm_start  <= (state_nx == S_GEMM_W)  && (state != S_GEMM_W);
            busy        <= !((state_nx == S_IDLE) || (state_nx == S_DONE) || (state_nx == S_ERR));
            done        <= (state_nx == S_DONE);
            if ((state == S_IDLE) && (state_nx == S_SCORE_W))
                head_sel <= '0;
            else if ((state == S_NEXT) && (state_nx == S_LOAD_W))
                head_sel <= head_sel + 1'b1;
            if ((state_nx == S_SM_W) && (state != S_SM_W))
                sm_seen <= 4'h0;
            else if (state == S_SM_W)
                sm_seen <= sm_seen | sm_done;
        end
    end

`ifdef ATTN_SEQ_WATCHDOG_EN
    // Per-wait-state cycle counter and sticky error report
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt  <= '0;
            err       <= 1'b0;
            err_stage <= 3'd0;
        end else begin
            if (state_nx != state)
                wdog_cnt <= '0;
            else if (stage_code != 3'd0)
                wdog_cnt <= wdog_cnt + 1'b1;
            err <= (state_nx == S_ERR);
            if (state_nx != S_ERR)
                err_stage <= 3'd0;
            else if (state != S_ERR)
                err_stage <= stage_code;
        end
    end
`else
    logic [WDOG_W-1:0] wdog_unused;
    assign wdog_unused = WDOG_LIMIT;
    assign err         = 1'b0;
    assign err_stage   = 3'd0;
`endif

endmodule

// File: tb/tb_mha_head_sequencer.sv
// tb/tb_mha_head_sequencer.sv - directed self-checking bench for mha_head_sequencer
module tb_mha_head_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic       score_start, load_start, scale_start, sm_start, gemm_start;
    logic       score_done, load_done, scale_done, gemm_done;
    logic [3:0] sm_done;
    logic [1:0] head_sel;
    logic       busy, done, err;
    logic [2:0] err_stage;

    logic       auto_en;
    logic       a_score, a_load, a_scale, a_sm, a_gemm;
    logic       m_score, m_load, m_scale, m_gemm;
    logic [3:0] m_sm;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int n_score = 0, n_load = 0, n_scale = 0, n_sm = 0, n_gemm = 0, n_done = 0;
    logic [7:0] hlog = 8'h0;
    logic       scale_prev = 1'b0;
    int c_score = 0, c_load = 0, c_scale = 0, c_sm = 0, c_gemm = 0;

    assign score_done = a_score | m_score;
    assign load_done  = a_load  | m_load;
    assign scale_done = a_scale | m_scale;
    assign sm_done    = {4{a_sm}} | m_sm;
    assign gemm_done  = a_gemm  | m_gemm;

    mha_head_sequencer #(.NUM_HEADS(4), .WDOG_W(16), .WDOG_LIMIT(16'd8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .score_start(score_start), .score_done(score_done),
        .load_start(load_start), .load_done(load_done),
        .scale_start(scale_start), .scale_done(scale_done),
        .sm_start(sm_start), .sm_done(sm_done),
        .gemm_start(gemm_start), .gemm_done(gemm_done),
        .head_sel(head_sel), .busy(busy), .done(done),
        .err(err), .err_stage(err_stage)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Stage model: count start pulses and, when enabled, answer each with a done 3 cycles later
    always @(negedge clk) begin
        a_score = 1'b0; a_load = 1'b0; a_scale = 1'b0; a_sm = 1'b0; a_gemm = 1'b0;
        if (c_score != 0) begin c_score--; if (c_score == 0) a_score = auto_en; end
        if (c_load  != 0) begin c_load--;  if (c_load  == 0) a_load  = auto_en; end
        if (c_scale != 0) begin c_scale--; if (c_scale == 0) a_scale = auto_en; end
        if (c_sm    != 0) begin c_sm--;    if (c_sm    == 0) a_sm    = auto_en; end
        if (c_gemm  != 0) begin c_gemm--;  if (c_gemm  == 0) a_gemm  = auto_en; end
        if (score_start) begin n_score++; c_score = 3; end
        if (load_start) begin n_load++; c_load = 3; hlog = {hlog[5:0], head_sel}; end
        if (scale_start && !scale_prev) begin n_scale++; c_scale = 3; end
        if (sm_start) begin n_sm++; c_sm = 3; end
        if (gemm_start) begin n_gemm++; c_gemm = 3; end
        if (done) n_done++;
        scale_prev = scale_start;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return score_start;
            1:       return load_start;
            2:       return scale_start;
            3:       return sm_start;
            4:       return gemm_start;
            default: return done;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int sel);
        int k = 0;
        while (!sel_sig(sel) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(sel_sig(sel)), 32'd1);
    endtask

    function automatic logic [4:0] starts();
        return {score_start, load_start, scale_start, sm_start, gemm_start};
    endfunction

    initial begin
        int t0, k, snap;
        rst = 1'b1; start = 1'b0; abort = 1'b0; auto_en = 1'b0;
        m_score = 1'b0; m_load = 1'b0; m_scale = 1'b0; m_gemm = 1'b0; m_sm = 4'h0;
        a_score = 1'b0; a_load = 1'b0; a_scale = 1'b0; a_sm = 1'b0; a_gemm = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_starts", 32'(starts()), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_head", 32'(head_sel), 32'd0);
        check("rst_err", 32'({err, err_stage}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal run, every stage answers 3 cycles after its start; start stays high across the end
        auto_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("start_lat_score", 32'(score_start), 32'd1);
        check("start_lat_busy", 32'(busy), 32'd1);
        t0 = cyc;
        k = 0;
        while (!done && k < 300) begin @(negedge clk); k++; end
        check("nom_done_seen", 32'(done), 32'd1);
        check("nom_run_len", 32'(cyc - t0), 32'd72);
        check("nom_busy_in_done", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check("nom_n_score", 32'(n_score), 32'd1);
        check("nom_n_load", 32'(n_load), 32'd4);
        check("nom_n_scale", 32'(n_scale), 32'd4);
        check("nom_n_sm", 32'(n_sm), 32'd4);
        check("nom_n_gemm", 32'(n_gemm), 32'd4);
        check("nom_n_done", 32'(n_done), 32'd1);
        check("nom_head_order", 32'(hlog), 32'h1B);
        check("nom_head_kept", 32'(head_sel), 32'd3);
        check("nom_no_retrigger", 32'(busy), 32'd0);
        start = 1'b0;
        auto_en = 1'b0;
        repeat (5) @(negedge clk);

        // Manual run: dones returned in the same cycle as their start pulse
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sig("man_score_start", 0);
        m_score = 1'b1; @(negedge clk); m_score = 1'b0;
        check("man_load_lat", 32'(load_start), 32'd1);
        m_load = 1'b1; @(negedge clk); m_load = 1'b0;
        check("man_scale_lat", 32'(scale_start), 32'd1);
        m_scale = 1'b1; @(negedge clk); m_scale = 1'b0;
        check("man_sm_lat", 32'(sm_start), 32'd1);
        check("man_scale_drop", 32'(scale_start), 32'd0);
        // Softmax rows finish out of order over four cycles
        m_sm = 4'b0001; @(negedge clk);
        check("sm_wait_0", 32'(gemm_start), 32'd0);
        m_sm = 4'b0100; @(negedge clk);
        check("sm_wait_2", 32'(gemm_start), 32'd0);
        m_sm = 4'b0010; @(negedge clk);
        check("sm_wait_1", 32'(gemm_start), 32'd0);
        m_sm = 4'b1000; @(negedge clk);
        m_sm = 4'b0000;
        check("sm_gemm_lat", 32'(gemm_start), 32'd1);
        m_gemm = 1'b1; @(negedge clk); m_gemm = 1'b0;
        check("next_no_load_yet", 32'(load_start), 32'd0);
        @(negedge clk);
        check("head1_load", 32'(load_start), 32'd1);
        check("head1_sel", 32'(head_sel), 32'd1);
        // Spurious gemm_done and a start re-pulse while waiting in LOAD_W
        @(negedge clk);
        m_gemm = 1'b1; start = 1'b1;
        @(negedge clk);
        m_gemm = 1'b0; start = 1'b0;
        @(negedge clk);
        check("spur_starts", 32'(starts()), 32'd0);
        check("spur_busy", 32'(busy), 32'd1);
        check("spur_head", 32'(head_sel), 32'd1);
        m_load = 1'b1; @(negedge clk); m_load = 1'b0;
        check("spur_still_load", 32'(scale_start), 32'd1);

        // Hung scale stage: SCALE_W entered in the cycle just checked
        repeat (7) @(negedge clk);
        check("wd_pre_err", 32'(err), 32'd0);
        check("wd_pre_scale", 32'(scale_start), 32'd1);
        @(negedge clk);
`ifdef ATTN_SEQ_WATCHDOG_EN
        check("wd_err", 32'(err), 32'd1);
        check("wd_stage", 32'(err_stage), 32'd3);
        check("wd_scale_low", 32'(scale_start), 32'd0);
        check("wd_busy_low", 32'(busy), 32'd0);
`else
        check("nowd_err", 32'({err, err_stage}), 32'd0);
        check("nowd_scale_held", 32'(scale_start), 32'd1);
        check("nowd_busy", 32'(busy), 32'd1);
`endif
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'({err, err_stage}), 32'd0);
        check("abort_starts", 32'(starts()), 32'd0);

        // Abort during GEMM_W of head 2
        auto_en = 1'b1;
        @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        k = 0;
        while (!(gemm_start && head_sel == 2'd2) && k < 300) begin @(negedge clk); k++; end
        check("h2_gemm_seen", 32'(gemm_start), 32'd1);
        snap = n_done;
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("h2_abort_busy", 32'(busy), 32'd0);
        check("h2_abort_starts", 32'(starts()), 32'd0);
        repeat (8) @(negedge clk);
        check("h2_abort_no_done", 32'(n_done - snap), 32'd0);
        check("h2_abort_idle", 32'(busy), 32'd0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        check("restart_score", 32'(score_start), 32'd1);
        check("restart_head", 32'(head_sel), 32'd0);

        // Reset asserted while in SM_W of head 1
        k = 0;
        while (!(sm_start && head_sel == 2'd1) && k < 300) begin @(negedge clk); k++; end
        check("h1_sm_seen", 32'(sm_start), 32'd1);
        @(negedge clk);
        rst = 1'b1; @(negedge clk);
        check("mrst_starts", 32'(starts()), 32'd0);
        check("mrst_busy_done", 32'({busy, done}), 32'd0);
        check("mrst_head", 32'(head_sel), 32'd0);
        check("mrst_err", 32'({err, err_stage}), 32'd0);
        rst = 1'b0;
        auto_en = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mha_head_sequencer.md
# mha_head_sequencer

Top-level controller for the 4-head attention datapath. It runs the QK^T score engine once, then steps each head through four stages: score fetch, scale, 4-row softmax and the 4x32 GEMM. It issues every stage-start, collects every stage-done and drives head_sel. An optional watchdog traps a stage that never completes and reports which stage hung.

## Interface
- NUM_HEADS, 4, heads processed per run (head_sel width = $clog2(NUM_HEADS), minimum 1)
- WDOG_W, 16, watchdog counter width
- WDOG_LIMIT, 16'hFFFF, wait-state cycles before a stage is declared hung

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level; a run begins on its rising edge
- abort  in  1  level; return to idle from any state
- score_start  out  1  one-cycle pulse, starts the all-heads score computation
- score_done  in  1  score engine finished
- load_start  out  1  one-cycle pulse, fetch the 16 scores of head head_sel
- load_done  in  1  fetch complete
- scale_start  out  1  level, held high for the whole scale wait
- scale_done  in  1  scale result valid
- sm_start  out  1  one-cycle pulse to all 4 softmax rows
- sm_done  in  4  per-row done; rows may finish in different cycles
- gemm_start  out  1  one-cycle pulse
- gemm_done  in  1  GEMM for the current head finished
- head_sel  out  $clog2(NUM_HEADS)  current head
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, all heads complete
- err  out  1  sticky, watchdog fired
- err_stage  out  3  hung stage: 1 score, 2 load, 3 scale, 4 softmax, 5 gemm; 0 when err=0

## Operation
- States: IDLE, SCORE_W, LOAD_W, SCALE_W, SM_W, GEMM_W, NEXT, DONE, ERR.
- All outputs are registered. Each stage pulse is asserted on the transition into its wait state, so the pulse is high during the first cycle of that wait state.
- IDLE:
  - start edge is start high with start_d low.
  - On a start edge: head_sel <= 0, go to SCORE_W.
- SCORE_W, on score_done: go to LOAD_W.
- LOAD_W, on load_done: go to SCALE_W.
- SCALE_W:
  - scale_start is held high throughout.
  - On scale_done: scale_start drops the next cycle; go to SM_W.
- SM_W:
  - sm_seen[3:0] is a sticky OR of sm_done, cleared on entry.
  - When sm_seen|sm_done equals 4'hF: go to GEMM_W.
- GEMM_W, on gemm_done: go to NEXT.
- NEXT:
  - If head_sel == NUM_HEADS-1: go to DONE.
  - Else: head_sel++ and go to LOAD_W. The score engine is not rerun.
- DONE: done=1 for one cycle, then go to IDLE. head_sel keeps its last value.
- A done input is sampled only in its own wait state. Done pulses arriving in any other state are ignored.
- Start edges while busy are ignored. start_d tracks start every cycle, so a start held high across the end of a run does not retrigger.
- abort:
  - Has priority over every transition.
  - Next state is IDLE; all start outputs go low; err and err_stage clear; done is not pulsed.
  - Abort together with a start edge in IDLE: stay in IDLE.
- busy is high in every state except IDLE, DONE and ERR.

## Timing
- Reset values: state IDLE, all start outputs 0, head_sel 0, busy 0, done 0, err 0, err_stage 0, start_d 0, watchdog counter 0.
- A start edge sampled at edge k gives score_start and busy high in cycle k+1.
- A done sampled at edge m gives the next stage's start high in cycle m+1. Exceptions:
  - gemm_done passes through NEXT, adding one cycle before load_start or done.
  - scale_done goes directly to SM_W, so sm_start is high in cycle m+1.
- Sequencing overhead per head is 5 cycles plus the sum of the stage latencies.
- A done input may assert in the same cycle as its start pulse and is accepted.

## Configuration
- ATTN_SEQ_WATCHDOG_EN defined:
  - A WDOG_W-bit counter clears on entry to each wait state and increments every cycle spent in it.
  - When the counter reaches WDOG_LIMIT without the awaited done, the next state is ERR: err=1, err_stage=code of the stage, all starts low, busy=0.
  - ERR is held until abort or rst.
  - A done arriving in the same cycle the limit is reached wins, and no error is raised.
- ATTN_SEQ_WATCHDOG_EN undefined:
  - No counter is built and wait states wait indefinitely.
  - err and err_stage are tied 0 and ERR is unreachable.

## Test plan
- Nominal run, NUM_HEADS=4, every done returned 3 cycles after its start:
  - Exactly 1 score_start, 4 each of load/sm/gemm starts.
  - head_sel steps 0,1,2,3.
  - One done pulse; busy drops in the done cycle.
- sm_done rows arrive at bits 0, 2, 1, 3 over four separate cycles: gemm_start occurs exactly 1 cycle after the bit-3 cycle.
- Spurious dones: gemm_done pulsed during LOAD_W and start re-pulsed mid-run → no state change, no second run.
- Watchdog with WDOG_LIMIT=8 and macro on, scale_done never asserted:
  - err=1, err_stage=3 and scale_start low exactly 8 cycles into SCALE_W.
  - Abort then returns to IDLE with err=0.
- Abort in GEMM_W of head 2 → IDLE next cycle, no done. A fresh start edge restarts at head 0 with score_start.
- Reset asserted mid-SM_W → all outputs at reset values on the following cycle.
